prio_irq_ctrl: RTL

- Eight-source vectored interrupt controller built around an 8-to-3 active-low priority encoder.
- Synchronises active-low request lines and latches falling edges as pending, applies a mask, and raises INT to the host.
- On ACK it hands over the 3-bit vector and tracks nested in-service levels until EOI.
- Sits between external request pins and the host sequencer.

---
 rtl/prio_irq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/prio_irq_ctrl.sv
// Eight-source vectored interrupt controller: synchronised falling-edge capture,
// masking, priority arbitration and nested in-service tracking with ACK/EOI handshake.
module prio_irq_ctrl #(
  parameter int unsigned  SYNC_STAGES = 2,
  parameter bit           NESTED      = 1'b1,
  localparam int unsigned NUM_SRC     = 8,
  localparam int unsigned VEC_W       = 3
) (
  input  logic               CLK,
  input  logic               nCR,
  input  logic [NUM_SRC-1:0] nIRQ,
  input  logic               MASK_WR,
  input  logic [NUM_SRC-1:0] MASK_IN,
  input  logic               ACK,
  input  logic               EOI,
  output logic               INT,
  output logic [VEC_W-1:0]   VEC,
  output logic               VEC_VLD,
  output logic [NUM_SRC-1:0] ISR,
  output logic [NUM_SRC-1:0] IRR,
  output logic               nGS
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_DELIVER
  } state_t;

  state_t             stateQ;
  state_t             stateNext;
  logic [NUM_SRC-1:0] syncQ [SYNC_STAGES];
  logic [NUM_SRC-1:0] histQ;
  logic [NUM_SRC-1:0] maskQ;
  logic [NUM_SRC-1:0] fallEdge;
  logic [NUM_SRC-1:0] pendMasked;
  logic [NUM_SRC-1:0] eoiClr;
  logic [NUM_SRC-1:0] ackSet;
  logic [VEC_W-1:0]   candIdx;
  logic [VEC_W-1:0]   isrTop;
  logic               eligible;
  logic               ackTake;

  // Priority encoder: index of the highest set bit (0 when none set).
  function automatic logic [VEC_W-1:0] topIdx(input logic [NUM_SRC-1:0] v);
    logic [VEC_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (v[i]) idx = VEC_W'(i);
    end
    return idx;
  endfunction

  // Input synchroniser plus history stage; idles high out of reset.
  always_ff @(posedge CLK or negedge nCR) begin
    if (!nCR) begin
      for (int k = 0; k < SYNC_STAGES; k++) syncQ[k] <= '1;
      histQ <= '1;
    end else begin
      syncQ[0] <= nIRQ;
      for (int k = 1; k < SYNC_STAGES; k++) syncQ[k] <= syncQ[k-1];
      histQ <= syncQ[SYNC_STAGES-1];
    end
  end

  assign fallEdge = histQ & ~syncQ[SYNC_STAGES-1];
  assign nGS      = ~|pendMasked;

  // Arbitration against the current mask and in-service level.
  always_comb begin
    pendMasked = IRR & ~maskQ;
    candIdx    = topIdx(pendMasked);
    isrTop     = topIdx(ISR);
    eoiClr     = '0;
    if (NESTED) begin
      eligible = (|pendMasked) && ((ISR == '0) || (candIdx > isrTop));
    end else begin
      eligible = (|pendMasked) && (ISR == '0);
    end
    if (EOI && (|ISR)) eoiClr = NUM_SRC'(1) << isrTop;
  end

  // Next-state logic for the INT/ACK handshake.
  always_comb begin
    stateNext = stateQ;
    ackTake   = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (eligible) stateNext = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!eligible) begin
          stateNext = ST_IDLE;
        end else if (ACK) begin
          stateNext = ST_DELIVER;
          ackTake   = 1'b1;
        end
      end
      ST_DELIVER: stateNext = ST_IDLE;
      default:    stateNext = ST_IDLE;
    endcase
    ackSet = ackTake ? (NUM_SRC'(1) << candIdx) : '0;
  end

  always_ff @(posedge CLK or negedge nCR) begin
    if (!nCR) begin
      stateQ  <= ST_IDLE;
      INT     <= 1'b0;
      VEC_VLD <= 1'b0;
      VEC     <= '0;
    end else begin
      stateQ  <= stateNext;
      INT     <= (stateNext == ST_ASSERT);
      VEC_VLD <= ackTake;
      if (ackTake) VEC <= candIdx;
    end
  end

  // EOI clears from the old ISR before the ACK bit lands; a fresh capture beats the ACK clear.
  always_ff @(posedge CLK or negedge nCR) begin
    if (!nCR) begin
      maskQ <= '1;
      ISR   <= '0;
      IRR   <= '0;
    end else begin
      if (MASK_WR) maskQ <= MASK_IN;
      ISR <= (ISR & ~eoiClr) | ackSet;
      IRR <= (IRR & ~ackSet) | fallEdge;
    end
  end

endmodule
